// File: rtl/dma_line_engine.sv
// rtl/dma_line_engine.sv - multi-line copy DMA engine on the memory-controller port
// Optional feature macro: DMA_LINE_CSUM_EN (cv_value becomes a running sum of written words)
module dma_line_engine #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 64,
  parameter int LINE_WORDS = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  num_lines,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        op,
  output logic [ADDR_W-1:0] io_address,
  input  logic              rd_valid,
  input  logic              wr_accept,
  input  logic              tx_done,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [63:0]       cv_value
);

  localparam int PTR_W = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(LINE_WORDS * (DATA_W / 8));
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(LINE_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_NEXT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [CNT_W-1:0]  lines_left_q;
  logic [PTR_W-1:0]  rptr_q, wptr_q;
  logic [PTR_W:0]    rcnt_q;
  logic [PTR_W:0]    rcnt_after;
  logic [DATA_W-1:0] line_buf [LINE_WORDS];
  logic              error_q;
  logic              rd_take;
  logic              start_ok;

  // A read word is only stored while the line buffer still has room.
  assign rd_take    = (state_q == S_READ) && rd_valid && (rcnt_q < FULL_CNT);
  assign rcnt_after = rcnt_q + (PTR_W + 1)'(rd_take);
  assign start_ok   = (state_q == S_IDLE) && start;
  assign error      = error_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and state-decoded outputs; nothing here looks at an input for an output.
  always_comb begin
    state_d    = state_q;
    busy       = 1'b1;
    done       = 1'b0;
    op         = 2'b00;
    io_address = '0;
    data_out   = '0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = (num_lines == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        op         = 2'b01;
        io_address = src_q;
        if (tx_done) state_d = S_WRITE;
      end
      S_WRITE: begin
        op         = 2'b11;
        io_address = dst_q;
        data_out   = line_buf[wptr_q];
        if (tx_done) state_d = S_NEXT;
      end
      S_NEXT: begin
        state_d = (lines_left_q == CNT_W'(1)) ? S_DONE : S_READ;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command registers, pointers, line counter and the sticky length-error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q        <= '0;
      dst_q        <= '0;
      lines_left_q <= '0;
      rptr_q       <= '0;
      wptr_q       <= '0;
      rcnt_q       <= '0;
      error_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            src_q        <= src_addr;
            dst_q        <= dst_addr;
            lines_left_q <= num_lines;
            rptr_q       <= '0;
            wptr_q       <= '0;
            rcnt_q       <= '0;
            error_q      <= 1'b0;
          end
        end
        S_READ: begin
          if (rd_take) begin
            rptr_q <= rptr_q + 1'b1;
            rcnt_q <= rcnt_after;
          end
          if (rd_valid && !rd_take) error_q <= 1'b1;
          if (tx_done && (rcnt_after < FULL_CNT)) error_q <= 1'b1;
        end
        S_WRITE: begin
          if (wr_accept) wptr_q <= wptr_q + 1'b1;
        end
        S_NEXT: begin
          src_q        <= src_q + LINE_BYTES;
          dst_q        <= dst_q + LINE_BYTES;
          lines_left_q <= lines_left_q - 1'b1;
          rptr_q       <= '0;
          wptr_q       <= '0;
          rcnt_q       <= '0;
        end
        default: ;
      endcase
    end
  end

  // Line buffer; entries not refilled by a short read keep their previous contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINE_WORDS; i++) line_buf[i] <= '0;
    end else if (rd_take) begin
      line_buf[rptr_q] <= data_in;
    end
  end

`ifdef DMA_LINE_CSUM_EN
  logic [63:0] cv_q;

  // Running sum of every word the controller consumes; held after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                cv_q <= '0;
    else if (start_ok)                         cv_q <= '0;
    else if ((state_q == S_WRITE) && wr_accept) cv_q <= cv_q + 64'(line_buf[wptr_q]);
  end

  assign cv_value = cv_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign cv_value        = '1;
`endif

endmodule

// File: tb/tb_dma_line_engine.sv
// tb/tb_dma_line_engine.sv - self-checking bench for dma_line_engine with a line-level model
module tb_dma_line_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] src_addr, dst_addr;
  logic [15:0] num_lines;
  logic        busy, done, error;
  logic [1:0]  op;
  logic [63:0] io_address;
  logic        rd_valid, wr_accept, tx_done;
  logic [31:0] data_in, data_out;
  logic [63:0] cv_value;

  dma_line_engine #(.DATA_W(32), .ADDR_W(64), .LINE_WORDS(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .num_lines(num_lines), .busy(busy), .done(done), .error(error), .op(op),
    .io_address(io_address), .rd_valid(rd_valid), .wr_accept(wr_accept), .tx_done(tx_done),
    .data_in(data_in), .data_out(data_out), .cv_value(cv_value)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_count = 0;

  // Count done pulses away from the active edge.
  always @(negedge clk) if (done === 1'b1) done_count++;

  // Reference model: buffer contents, sticky error and expected bus traffic per command.
  logic [31:0] ref_buf [16];
  bit          exp_err;
  logic [63:0] exp_sum;
  logic [63:0] exp_rd_addr[$], exp_wr_addr[$], obs_rd_addr[$], obs_wr_addr[$];
  logic [31:0] exp_wdata[$], obs_wdata[$];
  int          op_bad;
  int          abort_line = -1;
  int          abort_word = -1;

  function automatic logic [63:0] exp_cv();
`ifdef DMA_LINE_CSUM_EN
    return exp_sum;
`else
    return 64'hFFFF_FFFF_FFFF_FFFF;
`endif
  endfunction

  // Acts as the memory controller for one full command; returns positioned in the DONE cycle.
  task automatic run_command(input logic [63:0] s, input logic [63:0] d, input int nl, input int nread,
                             input bit rd_same, input bit wr_same, input bit poke, input bit gaps,
                             input bit seq_words);
    logic [31:0] w[$];
    exp_rd_addr.delete(); exp_wr_addr.delete(); exp_wdata.delete();
    obs_rd_addr.delete(); obs_wr_addr.delete(); obs_wdata.delete();
    op_bad = 0; exp_err = 0; exp_sum = '0;
    start = 1'b1; src_addr = s; dst_addr = d; num_lines = 16'(nl);
    @(posedge clk); #1;
    start = 1'b0; src_addr = {$urandom, $urandom}; dst_addr = {$urandom, $urandom};
    num_lines = 16'($urandom);
    for (int l = 0; l < nl; l++) begin
      w.delete();
      for (int i = 0; i < nread; i++) w.push_back(seq_words ? 32'(i + 1) : $urandom);
      exp_rd_addr.push_back(s + 64'(l) * 64'd64);
      exp_wr_addr.push_back(d + 64'(l) * 64'd64);
      for (int i = 0; i < nread && i < 16; i++) ref_buf[i] = w[i];
      if (nread != 16) exp_err = 1'b1;
      for (int j = 0; j < 16; j++) begin
        exp_wdata.push_back(ref_buf[j]);
        exp_sum += 64'(ref_buf[j]);
      end
      obs_rd_addr.push_back(io_address);
      if (op !== 2'b01 || busy !== 1'b1) op_bad++;
      for (int i = 0; i < nread; i++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          wr_accept = 1'b1;
          @(posedge clk); #1;
          wr_accept = 1'b0;
        end
        if (l == abort_line && i == abort_word) begin
          rst_n = 1'b0; #1;
          return;
        end
        rd_valid = 1'b1; data_in = w[i]; tx_done = rd_same && (i == nread - 1);
        @(posedge clk); #1;
        rd_valid = 1'b0; tx_done = 1'b0; data_in = $urandom;
      end
      if (!(rd_same && nread > 0)) begin
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
      end
      obs_wr_addr.push_back(io_address);
      if (op !== 2'b11 || busy !== 1'b1) op_bad++;
      for (int j = 0; j < 16; j++) begin
        if (poke && j == 3) begin
          start = 1'b1; src_addr = {$urandom, $urandom}; num_lines = 16'd5;
          @(posedge clk); #1;
          start = 1'b0;
        end
        if (gaps && $urandom_range(0, 3) == 0) begin
          rd_valid = 1'b1;
          @(posedge clk); #1;
          rd_valid = 1'b0;
        end
        obs_wdata.push_back(data_out);
        wr_accept = 1'b1; tx_done = wr_same && (j == 15);
        @(posedge clk); #1;
        wr_accept = 1'b0; tx_done = 1'b0;
      end
      if (!wr_same) begin
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
      end
      if (op !== 2'b00 || busy !== 1'b1) op_bad++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; src_addr = '0; dst_addr = '0; num_lines = '0;
    rd_valid = 0; wr_accept = 0; tx_done = 0; data_in = '0;
    for (int i = 0; i < 16; i++) ref_buf[i] = '0;
    exp_sum = '0;
    #1;
    n_checks++;
    if ({busy, done, error, op} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: busy/done/error/op=%b required 00000", {busy, done, error, op});
    end
    n_checks++;
    if (io_address !== 64'h0 || data_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus: io_address=%h data_out=%h required 0/0", io_address, data_out);
    end
    n_checks++;
    if (cv_value !== exp_cv()) begin
      n_fail++; $display("FAIL reset_cv: got %h required %h", cv_value, exp_cv());
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_line();
    int dc0 = done_count;
    run_command(64'h0, 64'h400, 1, 16, 0, 0, 0, 0, 1);
    n_checks++;
    if (op_bad != 0) begin n_fail++; $display("FAIL single_op: %0d bad op/busy samples required 0", op_bad); end
    n_checks++;
    if (obs_rd_addr[0] !== 64'h0 || obs_wr_addr[0] !== 64'h400) begin
      n_fail++; $display("FAIL single_addr: rd=%h wr=%h required 0/400", obs_rd_addr[0], obs_wr_addr[0]);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (obs_wdata[i] !== 32'(i + 1)) begin
        n_fail++; $display("FAIL single_data[%0d]: got %h required %h", i, obs_wdata[i], 32'(i + 1));
      end
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1 || error !== 1'b0) begin
      n_fail++; $display("FAIL single_done: done=%b busy=%b error=%b required 1/1/0", done, busy, error);
    end
    @(posedge clk); #1;
    n_checks++;
`ifdef DMA_LINE_CSUM_EN
    if (cv_value !== 64'h88) begin n_fail++; $display("FAIL single_cv: got %h required 88", cv_value); end
`else
    if (cv_value !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL single_cv: got %h required all-ones", cv_value); end
`endif
    n_checks++;
    if (busy !== 1'b0 || done_count - dc0 != 1) begin
      n_fail++; $display("FAIL single_end: busy=%b done pulses=%0d required 0/1", busy, done_count - dc0);
    end
  endtask

  task automatic test_three_lines();
    int dc0 = done_count;
    run_command(64'h1000, 64'h2000, 3, 16, 0, 0, 0, 1, 0);
    for (int l = 0; l < 3; l++) begin
      n_checks++;
      if (obs_rd_addr[l] !== 64'h1000 + 64'(l) * 64'h40 || obs_wr_addr[l] !== 64'h2000 + 64'(l) * 64'h40) begin
        n_fail++; $display("FAIL three_addr[%0d]: rd=%h wr=%h required %h/%h", l, obs_rd_addr[l], obs_wr_addr[l],
                           64'h1000 + 64'(l) * 64'h40, 64'h2000 + 64'(l) * 64'h40);
      end
    end
    for (int i = 0; i < exp_wdata.size(); i++) begin
      n_checks++;
      if (obs_wdata[i] !== exp_wdata[i]) begin
        n_fail++; $display("FAIL three_data[%0d]: got %h required %h", i, obs_wdata[i], exp_wdata[i]);
      end
    end
    n_checks++;
    if (op_bad != 0 || error !== 1'b0) begin
      n_fail++; $display("FAIL three_op_err: bad=%0d error=%b required 0/0", op_bad, error);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done_count - dc0 != 1 || cv_value !== exp_cv()) begin
      n_fail++; $display("FAIL three_end: done pulses=%0d cv=%h required 1/%h", done_count - dc0, cv_value, exp_cv());
    end
  endtask

  task automatic test_read_errors(input int nread, input string tag);
    run_command({$urandom, $urandom}, {$urandom, $urandom}, 1, nread, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (obs_wdata[i] !== exp_wdata[i]) begin
        n_fail++; $display("FAIL %s_data[%0d]: got %h required %h", tag, i, obs_wdata[i], exp_wdata[i]);
      end
    end
    n_checks++;
    if (error !== 1'b1 || done !== 1'b1) begin
      n_fail++; $display("FAIL %s_error: error=%b done=%b required 1/1", tag, error, done);
    end
    @(posedge clk); #1;
    n_checks++;
    if (error !== 1'b1 || cv_value !== exp_cv()) begin
      n_fail++; $display("FAIL %s_hold: error=%b cv=%h required 1/%h", tag, error, cv_value, exp_cv());
    end
  endtask

  task automatic test_zero_lines();
    int dc0 = done_count;
    run_command(64'h5000, 64'h6000, 0, 16, 0, 0, 0, 0, 0);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1 || op !== 2'b00 || error !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: done=%b busy=%b op=%b error=%b required 1/1/00/0", done, busy, op, error);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || op !== 2'b00 || done_count - dc0 != 1) begin
      n_fail++; $display("FAIL zero_after: busy=%b done=%b op=%b pulses=%0d required 0/0/00/1", busy, done, op, done_count - dc0);
    end
    n_checks++;
    if (cv_value !== exp_cv()) begin n_fail++; $display("FAIL zero_cv: got %h required %h", cv_value, exp_cv()); end
  endtask

  task automatic test_simultaneous();
    int dc0 = done_count;
    run_command(64'h7000, 64'h8000, 1, 16, 1, 1, 1, 1, 0);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (obs_wdata[i] !== exp_wdata[i]) begin
        n_fail++; $display("FAIL simul_data[%0d]: got %h required %h", i, obs_wdata[i], exp_wdata[i]);
      end
    end
    n_checks++;
    if (error !== 1'b0 || op_bad != 0 || done !== 1'b1) begin
      n_fail++; $display("FAIL simul_state: error=%b bad=%0d done=%b required 0/0/1", error, op_bad, done);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done_count - dc0 != 1 || cv_value !== exp_cv()) begin
      n_fail++; $display("FAIL simul_end: busy=%b pulses=%0d cv=%h required 0/1/%h", busy, done_count - dc0, cv_value, exp_cv());
    end
  endtask

  task automatic test_addr_wrap();
    run_command(64'hFFFF_FFFF_FFFF_FFC0, 64'hFFFF_FFFF_FFFF_FF80, 2, 16, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs_rd_addr[1] !== 64'h0 || obs_wr_addr[1] !== 64'hFFFF_FFFF_FFFF_FFC0) begin
      n_fail++; $display("FAIL wrap_addr: rd=%h wr=%h required 0/ffffffffffffffc0", obs_rd_addr[1], obs_wr_addr[1]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int dc0 = done_count;
    abort_line = 1; abort_word = 5;
    run_command(64'h3000, 64'h4000, 3, 16, 0, 0, 0, 0, 0);
    abort_line = -1; abort_word = -1;
    for (int i = 0; i < 16; i++) ref_buf[i] = '0;
    exp_sum = '0;
    n_checks++;
    if ({busy, done, error, op} !== 5'b0 || io_address !== 64'h0 || data_out !== 32'h0) begin
      n_fail++; $display("FAIL abort_outputs: ctrl=%b io=%h dout=%h required 0/0/0", {busy, done, error, op}, io_address, data_out);
    end
    n_checks++;
    if (cv_value !== exp_cv()) begin n_fail++; $display("FAIL abort_cv: got %h required %h", cv_value, exp_cv()); end
    rd_valid = 0; tx_done = 0; wr_accept = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (done_count != dc0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_nodone: pulses=%0d busy=%b required 0/0", done_count - dc0, busy);
    end
    run_command(64'h9000, 64'hA000, 1, 4, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (obs_wdata[i] !== exp_wdata[i]) begin
        n_fail++; $display("FAIL abort_buf[%0d]: got %h required %h", i, obs_wdata[i], exp_wdata[i]);
      end
    end
    @(posedge clk); #1;
    run_command(64'hB000, 64'hC000, 1, 16, 0, 0, 0, 1, 0);
    n_checks++;
    if (error !== 1'b0 || done !== 1'b1 || obs_wdata[15] !== exp_wdata[15]) begin
      n_fail++; $display("FAIL abort_restart: error=%b done=%b last=%h required 0/1/%h", error, done, obs_wdata[15], exp_wdata[15]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int dc0 = done_count;
      int nl = $urandom_range(1, 3);
      int nread = ($urandom_range(0, 2) == 0) ? $urandom_range(13, 18) : 16;
      bit rs = 1'($urandom_range(0, 1));
      bit ws = 1'($urandom_range(0, 1));
      int bad = 0;
      run_command({$urandom, $urandom}, {$urandom, $urandom}, nl, nread, rs, ws, 0, 1, 0);
      for (int l = 0; l < nl; l++)
        if (obs_rd_addr[l] !== exp_rd_addr[l] || obs_wr_addr[l] !== exp_wr_addr[l]) bad++;
      for (int i = 0; i < exp_wdata.size(); i++)
        if (obs_wdata[i] !== exp_wdata[i]) bad++;
      n_checks++;
      if (bad != 0 || op_bad != 0) begin
        n_fail++; $display("FAIL rand%0d_traffic: %0d data/addr and %0d op mismatches required 0", it, bad, op_bad);
      end
      n_checks++;
      if (error !== exp_err) begin n_fail++; $display("FAIL rand%0d_error: got %b required %b", it, error, exp_err); end
      @(posedge clk); #1;
      n_checks++;
      if (done_count - dc0 != 1 || cv_value !== exp_cv()) begin
        n_fail++; $display("FAIL rand%0d_end: pulses=%0d cv=%h required 1/%h", it, done_count - dc0, cv_value, exp_cv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_three_lines();
    test_read_errors(12, "short");
    test_zero_lines();
    test_read_errors(17, "long");
    test_simultaneous();
    test_addr_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_line_engine.md
# dma_line_engine

Parametrised line-copy DMA engine that sits on the memory-controller port (op / io_address / data buses). On a start command it reads `NUM_LINES` lines of `LINE_WORDS` words from a source address into an internal line buffer. It then writes each line back to a destination address, advancing both addresses per line. It supersedes the fixed single-line, fixed-address loopback, adding programmable addresses, multi-line transfers, a per-word write handshake and error reporting.

## Interface
- `DATA_W`, 32: data word width in bits; a multiple of 8.
- `ADDR_W`, 64: address width.
- `LINE_WORDS`, 16: words per line; a power of two, ≥2.
- `CNT_W`, 16: width of the line-count input.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: command strobe; sampled only in IDLE.
- `src_addr`  in  ADDR_W: source base address; captured on an accepted start.
- `dst_addr`  in  ADDR_W: destination base address; captured on an accepted start.
- `num_lines`  in  CNT_W: number of lines to copy; captured on an accepted start.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse at the end of a command.
- `error`  out  1: sticky flag for a short or long read; cleared by an accepted start.
- `op`  out  2: 2'b00 idle, 2'b01 read, 2'b11 write.
- `io_address`  out  ADDR_W: current line address.
- `rd_valid`  in  1: read word present on `data_in` this cycle.
- `wr_accept`  in  1: controller consumed `data_out` this cycle.
- `tx_done`  in  1: controller finished the current line transaction.
- `data_in`  in  DATA_W: read data.
- `data_out`  out  DATA_W: write data.
- `cv_value`  out  64: completion value (see Configuration).

## Operation
- States: IDLE, READ, WRITE, NEXT, DONE.
- **IDLE**
  - op=00, io_address=0, data_out=0.
  - `start` captures src, dst and num_lines, clears `error`, and clears the rd/wr pointers.
  - If num_lines≠0, go to READ. If num_lines=0, go to DONE with no bus activity.
- **READ**
  - op=01, io_address=current src.
  - Each cycle with `rd_valid`: buf[rptr]←data_in, rptr++. Pointer width is log2(LINE_WORDS).
  - A `rd_valid` when LINE_WORDS words are already captured is dropped and sets `error`.
  - On `tx_done`, go to WRITE.
  - `rd_valid` and `tx_done` in the same cycle: the word is captured first, then the transition happens.
  - If fewer than LINE_WORDS words were captured at `tx_done`, set `error`. Uncaptured entries keep their old contents.
- **WRITE**
  - op=11, io_address=current dst, data_out=buf[wptr] (combinational).
  - `wr_accept` increments wptr, wrapping modulo LINE_WORDS.
  - On `tx_done`, go to NEXT. `wr_accept` in the same cycle still counts.
- **NEXT** (one cycle)
  - op=00.
  - src += LINE_WORDS·DATA_W/8 and dst += the same amount, both modulo 2^ADDR_W.
  - lines_left--. Clear rptr, wptr and the read-word count.
  - If lines_left becomes 0, go to DONE; otherwise go to READ.
- **DONE** (one cycle): `done`=1, then go to IDLE.
- `start` outside IDLE is ignored.
- `rd_valid` outside READ is ignored. `wr_accept` outside WRITE is ignored. `tx_done` outside READ/WRITE is ignored.

## Timing
- Reset values: state IDLE, busy=0, done=0, error=0, op=00, io_address=0, data_out=0, buffer all zeros, pointers 0, cv_value per Configuration.
- Asserting rst_n low mid-command aborts immediately. No done pulse is produced.
- Start latency: start sampled at edge k gives op=01 and busy=1 from cycle k+1.
- Phase transitions take effect on the edge that samples `tx_done`.
- A single line costs read cycles + write cycles + 1 (NEXT) + 1 (DONE).
- A command with num_lines=0 gives done in cycle k+1 and busy high for exactly one cycle.
- `done` and `busy` are both high in the DONE cycle. A start in the cycle after DONE is accepted.
- Every output is registered or decoded from state and registers only. There are no combinational paths from inputs to outputs.

## Configuration
- `DMA_LINE_CSUM_EN` defined:
  - cv_value is a 64-bit running sum of every word consumed by `wr_accept` (zero-extended to 64 bits, wrapping modulo 2^64).
  - cv_value resets to 0, is cleared on an accepted start, and holds its value after done.
- `DMA_LINE_CSUM_EN` not defined: cv_value is constant all-ones and no adder is synthesised.

## Test plan
- **Single line, defaults.**
  - Stimulus: start with src=0x0, dst=0x400, num_lines=1. Controller returns 16 words 0x1..0x10 then tx_done, then accepts 16 writes then tx_done.
  - Required: op goes 01→11; io_address is 0x0 then 0x400; data_out sequence is 0x1..0x10; done pulses once; error=0; cv_value=0x88 (CSUM) or all-ones.
- **Three lines.**
  - Stimulus: src=0x1000, dst=0x2000.
  - Required: read addresses 0x1000/0x1040/0x1080; write addresses 0x2000/0x2040/0x2080; exactly one done.
- **num_lines=0.**
  - Required: done one cycle after start, op stays 00, busy high for exactly one cycle.
- **Read length errors.**
  - Stimulus: 12 rd_valid then tx_done.
  - Required: error=1, words 0..11 written, entries 12..15 hold their previous values.
  - Stimulus: 17 rd_valid before tx_done.
  - Required: error=1, the 17th word is dropped.
- **Simultaneous events and ignored start.**
  - Stimulus: rd_valid together with tx_done on the 16th word; wr_accept together with tx_done on the 16th write; start asserted during WRITE.
  - Required: all 16 words captured and written, the start is ignored, error=0.
- **Reset mid-operation.**
  - Stimulus: rst_n low during READ of line 2.
  - Required: all outputs return to reset values, no done pulse; a new start completes normally.
